// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped switch/button input port.
// No timing of its own; no backpressure.
package mmio_pkg;

   localparam int          MMIO_IN_WIDTH     = 12;
   localparam int          MMIO_IN_CNT_W     = 20;
   localparam logic [31:0] MMIO_IN_BASE_ADDR = 32'h0000_0080;

   typedef enum logic [1:0] {
      MMIO_IN_DATA = 2'd0,
      MMIO_IN_RAW  = 2'd1,
      MMIO_IN_EDGE = 2'd2,
      MMIO_IN_MASK = 2'd3
   } mmio_in_reg_e;

   typedef logic [MMIO_IN_WIDTH-1:0] mmio_in_vec_t;

   function automatic logic [31:0] mmio_in_zext(input mmio_in_vec_t v);
      return {{(32-MMIO_IN_WIDTH){1'b0}}, v};
   endfunction

endpackage

// File: rtl/sync_debounce.sv
// One-bit 2-FF synchronizer followed by a saturating stability counter.
// Latency: raw -> sync 2 clocks, sync -> deb DEBOUNCE_CYCLES clocks; no backpressure.
module sync_debounce
   import mmio_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic sync,
   output logic deb,
   output logic rise
);

   localparam logic [MMIO_IN_CNT_W-1:0] CNT_LAST = MMIO_IN_CNT_W'(DEBOUNCE_CYCLES - 1);

   logic                     meta;
   logic [MMIO_IN_CNT_W-1:0] cnt;
   logic                     settle;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta <= 1'b0;
         sync <= 1'b0;
      end else begin
         meta <= raw;
         sync <= meta;
      end
   end

   // settle is high in the cycle before deb takes the new level
   assign settle = (sync != deb) && (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
         deb <= 1'b0;
      end else if (sync == deb) begin
         cnt <= '0;
      end else if (settle) begin
         deb <= sync;
         cnt <= '0;
      end else begin
         cnt <= cnt + MMIO_IN_CNT_W'(1);
      end
   end

   // Combinational so EDGE/irq register on the same edge as deb
   assign rise = settle & sync;

endmodule

// File: rtl/mmio_switch_in.sv
// Memory-mapped debounced switch/button port with sticky edge flags; MMIO_IN_IRQ_EN adds MASK and irq.
// Latency: rd/hit combinational, stores visible next cycle; single-cycle access, no backpressure.
module mmio_switch_in
   import mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR       = MMIO_IN_BASE_ADDR,
   parameter int          DEBOUNCE_CYCLES = 500000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  switches,
   input  logic [3:0]  buttons,
   input  logic [31:0] addr,
   input  logic        we,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   output logic        hit,
   output logic        irq
);

   mmio_in_vec_t raw_in;
   mmio_in_vec_t sync_v;
   mmio_in_vec_t deb_v;
   mmio_in_vec_t rise_v;
   mmio_in_vec_t edge_q;
   mmio_in_vec_t edge_clr;
   mmio_in_vec_t edge_next;
   mmio_in_vec_t mask_q;
   mmio_in_reg_e sel;
   logic         wr;
   logic         unused_bits;

   assign raw_in = {buttons, switches};

   for (genvar i = 0; i < MMIO_IN_WIDTH; i++) begin : g_in
      sync_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_sync_debounce (
         .clk  (clk),
         .reset(reset),
         .raw  (raw_in[i]),
         .sync (sync_v[i]),
         .deb  (deb_v[i]),
         .rise (rise_v[i])
      );
   end

   assign hit = (addr[31:4] == BASE_ADDR[31:4]);
   assign sel = mmio_in_reg_e'(addr[3:2]);
   assign wr  = we && hit;

   assign edge_clr  = (wr && sel == MMIO_IN_EDGE) ? wd[MMIO_IN_WIDTH-1:0] : '0;
   // A new rising edge beats a simultaneous clear of the same bit
   assign edge_next = (edge_q & ~edge_clr) | rise_v;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         edge_q <= '0;
      end else begin
         edge_q <= edge_next;
      end
   end

`ifdef MMIO_IN_IRQ_EN
   mmio_in_vec_t mask_next;

   assign mask_next = (wr && sel == MMIO_IN_MASK) ? wd[MMIO_IN_WIDTH-1:0] : mask_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mask_q <= '0;
         irq    <= 1'b0;
      end else begin
         mask_q <= mask_next;
         irq    <= |(edge_next & mask_next);
      end
   end
`else
   assign mask_q = '0;
   assign irq    = 1'b0;
`endif

   always_comb begin
      rd = '0;
      if (hit) begin
         case (sel)
            MMIO_IN_DATA: rd = mmio_in_zext(deb_v);
            MMIO_IN_RAW:  rd = mmio_in_zext(sync_v);
            MMIO_IN_EDGE: rd = mmio_in_zext(edge_q);
            MMIO_IN_MASK: rd = mmio_in_zext(mask_q);
            default:      rd = '0;
         endcase
      end
   end

   // Byte offset and upper store bits carry no meaning for this port
   assign unused_bits = ^{addr[1:0], wd[31:MMIO_IN_WIDTH]};

endmodule

// File: tb/tb_mmio_switch_in.sv
// Bench for mmio_switch_in: queue-based debounce model plus directed literal checks.
module tb_mmio_switch_in;

   localparam int DC = 4;

   logic        clk;
   logic        reset;
   logic [7:0]  switches;
   logic [3:0]  buttons;
   logic [31:0] addr;
   logic        we;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        hit;
   logic        irq;

   int n_cmp = 0;
   int n_bad = 0;

   mmio_switch_in #(
      .BASE_ADDR      (32'h0000_0080),
      .DEBOUNCE_CYCLES(DC)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .switches(switches),
      .buttons (buttons),
      .addr    (addr),
      .we      (we),
      .wd      (wd),
      .rd      (rd),
      .hit     (hit),
      .irq     (irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         if (n_bad <= 40)
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a bit's debounced level flips once the last DC
   // synchronized samples all disagree with it.
   logic [11:0] m_s1, m_sync, m_deb, m_edge, m_mask;
   logic        m_irq;
   logic [11:0] shist[$];

   task automatic model_step();
      logic [11:0] rise;
      logic [11:0] clr;
      bit          all_ne;
      shist.push_back(m_sync);
      if (shist.size() > DC) void'(shist.pop_front());
      rise = '0;
      if (shist.size() == DC) begin
         for (int i = 0; i < 12; i++) begin
            all_ne = 1'b1;
            foreach (shist[j]) if (shist[j][i] == m_deb[i]) all_ne = 1'b0;
            if (all_ne) begin
               m_deb[i] = ~m_deb[i];
               rise[i]  = m_deb[i];
            end
         end
      end
      m_sync = m_s1;
      m_s1   = {buttons, switches};
      clr    = '0;
      if (we && addr[31:4] == 28'h8) begin
         if (addr[3:2] == 2'd2) clr = wd[11:0];
`ifdef MMIO_IN_IRQ_EN
         if (addr[3:2] == 2'd3) m_mask = wd[11:0];
`endif
      end
      m_edge = (m_edge & ~clr) | rise;
      m_irq  = |(m_edge & m_mask);
   endtask

   initial begin
      m_s1 = '0; m_sync = '0; m_deb = '0; m_edge = '0; m_mask = '0; m_irq = 1'b0;
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            m_s1 = '0; m_sync = '0; m_deb = '0; m_edge = '0; m_mask = '0; m_irq = 1'b0;
            shist.delete();
         end else begin
            model_step();
         end
      end
   end

   // Every-cycle comparison of all outputs against the model
   initial begin
      logic        e_hit;
      logic [31:0] e_rd;
      forever begin
         @(negedge clk);
         e_hit = (addr[31:4] == 28'h8);
         e_rd  = '0;
         if (e_hit) begin
            case (addr[3:2])
               2'd0: e_rd = {20'b0, m_deb};
               2'd1: e_rd = {20'b0, m_sync};
               2'd2: e_rd = {20'b0, m_edge};
               default: e_rd = {20'b0, m_mask};
            endcase
         end
         chk("model_hit", {31'b0, hit}, {31'b0, e_hit});
         chk("model_rd", rd, e_rd);
         chk("model_irq", {31'b0, irq}, {31'b0, m_irq});
      end
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      addr = a; wd = d; we = 1'b1;
      tick(1);
      we = 1'b0;
   endtask

   // Checks after the current cycle's edge, then advances one edge
   task automatic expect_rd(input logic [31:0] a, input logic [31:0] e, input string name);
      addr = a; we = 1'b0;
      @(negedge clk);
      chk(name, rd, e);
      tick(1);
   endtask

   task automatic expect_irq(input logic e, input string name);
      @(negedge clk);
      chk(name, {31'b0, irq}, {31'b0, e});
      tick(1);
   endtask

   initial begin
      reset = 1'b1; switches = 8'h00; buttons = 4'h0;
      addr = 32'h80; we = 1'b0; wd = '0;
      #1 reset = 1'b0;
      switches = 8'hFF;
      tick(2);
      expect_rd(32'h80, 32'h0, "reset_data");
      expect_rd(32'h88, 32'h0, "reset_edge");
      expect_irq(1'b0, "reset_irq");

      reset = 1'b1;
      addr  = 32'h80;
      tick(5);
      expect_rd(32'h80, 32'h000, "release_data_early");
      expect_rd(32'h80, 32'h0FF, "release_data");
      expect_rd(32'h88, 32'h0FF, "release_edge");
      store(32'h88, 32'hFFF);
      expect_rd(32'h88, 32'h000, "edge_w1c");

      buttons = 4'h1;
      tick(3);
      buttons = 4'h0;
      tick(8);
      expect_rd(32'h80, 32'h0FF, "glitch_data");
      expect_rd(32'h88, 32'h000, "glitch_edge");

      buttons = 4'h1;
      tick(5);
      expect_rd(32'h80, 32'h0FF, "pulse_data_early");
      expect_rd(32'h80, 32'h1FF, "pulse_data");
      expect_rd(32'h88, 32'h100, "pulse_edge");
      buttons = 4'h0;
      tick(8);
      expect_rd(32'h80, 32'h0FF, "fall_data");
      store(32'h88, 32'h100);
      expect_rd(32'h88, 32'h000, "fall_edge_clear");

      buttons = 4'h1;
      tick(5);
      store(32'h88, 32'h100);
      expect_rd(32'h88, 32'h100, "race_set_wins");
      store(32'h88, 32'h100);
      expect_rd(32'h88, 32'h000, "race_repeat_clear");
      buttons = 4'h0;
      tick(8);

      addr = 32'h90;
      @(negedge clk);
      chk("decode_miss_hit", {31'b0, hit}, 32'h0);
      chk("decode_miss_rd", rd, 32'h0);
      tick(1);
      expect_rd(32'h84, 32'h0FF, "decode_raw");
      store(32'h80, 32'hFFFF_FFFF);
      expect_rd(32'h83, 32'h0FF, "data_readonly");

      store(32'h88, 32'hFFF);
`ifdef MMIO_IN_IRQ_EN
      switches = 8'hFE;
      tick(8);
      store(32'h88, 32'hFFF);
      store(32'h8C, 32'h001);
      expect_rd(32'h8C, 32'h001, "mask_read");
      switches = 8'hFF;
      tick(6);
      expect_irq(1'b1, "irq_set");
      store(32'h88, 32'h001);
      expect_irq(1'b0, "irq_clear");
      switches = 8'hFD;
      tick(8);
      switches = 8'hFF;
      tick(8);
      expect_irq(1'b0, "irq_masked");
      expect_rd(32'h88, 32'h002, "masked_edge");
`else
      store(32'h8C, 32'hFFF);
      expect_rd(32'h8C, 32'h000, "mask_absent");
      switches = 8'hFE;
      tick(8);
      switches = 8'hFF;
      tick(8);
      expect_irq(1'b0, "irq_absent");
      expect_rd(32'h88, 32'h001, "poll_edge");
`endif

      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 5) == 0) begin
            if ($urandom_range(0, 2) == 0)
               buttons[$urandom_range(0, 3)] ^= 1'b1;
            else
               switches[$urandom_range(0, 7)] ^= 1'b1;
         end
         addr = 32'h80 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
         we   = ($urandom_range(0, 3) == 0);
         wd   = $urandom;
         if ($urandom_range(0, 15) != 0) wd[11:0] = 12'($urandom_range(0, 7)) << $urandom_range(0, 9);
         reset = ($urandom_range(0, 599) != 0);
         tick(1);
         reset = 1'b1;
      end
      we = 1'b0;
      tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
